// File: rtl/byte_ram_512_pkg.sv
// ----------------------------------------------------------------------------
// byte_ram_512_pkg
// Shared definitions for the byte-addressed main memory of the MIPS
// multicycle datapath: the opcodes that select an access size, the access
// size enum and the handshake FSM state enum.
// Optional feature macro used by the memory: BYTE_RAM_ALIGN_ERR_EN.
// ----------------------------------------------------------------------------
package byte_ram_512_pkg;

   // MIPS opcodes that change the access width; every other code is a word
   localparam logic [5:0] OPC_LB  = 6'h20;
   localparam logic [5:0] OPC_LH  = 6'h21;
   localparam logic [5:0] OPC_LW  = 6'h23;
   localparam logic [5:0] OPC_LBU = 6'h24;
   localparam logic [5:0] OPC_LHU = 6'h25;
   localparam logic [5:0] OPC_SB  = 6'h28;
   localparam logic [5:0] OPC_SH  = 6'h29;
   localparam logic [5:0] OPC_SW  = 6'h2B;

   typedef enum logic [1:0] {
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD
   } size_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

endpackage

// File: rtl/byte_ram_size_decode.sv
// ----------------------------------------------------------------------------
// byte_ram_size_decode
// Combinational decode of a MIPS opcode into an access size and a
// sign-extension flag. Only LB and LH sign-extend; unknown codes (LW,
// instruction fetch, ...) fall back to a word access.
// Ports:
//   opc        in   6  MIPS opcode
//   size       out  2  access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   is_signed  out  1  sign-extend read data
// ----------------------------------------------------------------------------
module byte_ram_size_decode
   import byte_ram_512_pkg::*;
(
   input  logic [5:0] opc,
   output size_t      size,
   output logic       is_signed
);

   // Word, unsigned is the default so every unlisted opcode becomes a word access
   always_comb begin
      size      = SZ_WORD;
      is_signed = 1'b0;
      case (opc)
         OPC_LB: begin
            size      = SZ_BYTE;
            is_signed = 1'b1;
         end
         OPC_LBU, OPC_SB: size = SZ_BYTE;
         OPC_LH: begin
            size      = SZ_HALF;
            is_signed = 1'b1;
         end
         OPC_LHU, OPC_SH: size = SZ_HALF;
         OPC_LW, OPC_SW:  size = SZ_WORD;
         default:         size = SZ_WORD;
      endcase
   end

endmodule

// File: rtl/byte_ram_512.sv
// ----------------------------------------------------------------------------
// byte_ram_512
// Big-endian, byte-addressed DEPTH x 8 memory with a MOV/MOC request /
// acknowledge handshake. A request is latched in IDLE, completes after
// ACCESS_CYCLES clocks in BUSY, and is acknowledged from DONE, so MOC rises
// ACCESS_CYCLES+1 edges after MOV is first sampled. Halfword and word
// addresses are silently aligned down; byte indices wrap modulo DEPTH
// (DEPTH is expected to be a power of two). The storage array Mem is not
// cleared by reset.
// Optional feature: define BYTE_RAM_ALIGN_ERR_EN to add the align_err output,
// raised together with MOC when the requested address was misaligned.
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous reset, active low
//   align_err  out  1   misaligned request flag (BYTE_RAM_ALIGN_ERR_EN only)
//   DataOut    out  32  read data, zero/sign extended per OpC
//   MOC        out  1   memory operation complete (level)
//   DMOC       out  1   one-cycle completion pulse
//   RW         in   1   1 = read, 0 = write
//   MOV        in   1   memory operation valid (request)
//   Address    in   AW  byte address
//   DataIn     in   32  write data, low bits used for byte/half stores
//   OpC        in   6   MIPS opcode selecting the access size
// ----------------------------------------------------------------------------
module byte_ram_512
   import byte_ram_512_pkg::*;
#(
   parameter int DEPTH         = 512,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     reset,
`ifdef BYTE_RAM_ALIGN_ERR_EN
   output logic                     align_err,
`endif
   output logic [31:0]              DataOut,
   output logic                     MOC,
   output logic                     DMOC,
   input  logic                     RW,
   input  logic                     MOV,
   input  logic [$clog2(DEPTH)-1:0] Address,
   input  logic [31:0]              DataIn,
   input  logic [5:0]               OpC
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);

   logic [7:0] Mem [0:DEPTH-1];

   state_t        state, next_state;
   logic [CW-1:0] cnt, next_cnt;
   logic          do_access;

   logic          rw_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic [5:0]    opc_q;

   size_t         size;
   logic          is_signed;
   logic [AW-1:0] a0, a1, a2, a3;
   logic [7:0]    b0, b1, b2, b3;
   logic [31:0]   rdata;

   // Size is decoded from the latched opcode so OpC may change after acceptance
   byte_ram_size_decode u_size_decode (
      .opc       (opc_q),
      .size      (size),
      .is_signed (is_signed)
   );

   // State and countdown register; reset aborts any access in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // Next-state logic; do_access marks the single edge on which Mem is
   // written or read data is captured
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      do_access  = 1'b0;
      case (state)
         IDLE: begin
            if (MOV) begin
               next_state = BUSY;
               next_cnt   = CNT_LOAD;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               do_access  = 1'b1;
               next_state = DONE;
            end else begin
               next_cnt = cnt - CW'(1);
            end
         end
         DONE: begin
            if (!MOV) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Request operands are captured once on acceptance and held until the
   // next request, which makes the inputs don't-care during BUSY and DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rw_q    <= 1'b1;
         addr_q  <= '0;
         wdata_q <= '0;
         opc_q   <= '0;
      end else if (state == IDLE && MOV) begin
         rw_q    <= RW;
         addr_q  <= Address;
         wdata_q <= DataIn;
         opc_q   <= OpC;
      end
   end

   // Align the base address down to the access size; the following byte
   // indices wrap naturally in AW-bit arithmetic
   always_comb begin
      a0 = addr_q;
      if (size == SZ_HALF) a0[0] = 1'b0;
      else if (size == SZ_WORD) a0[1:0] = 2'b00;
      a1 = a0 + AW'(1);
      a2 = a0 + AW'(2);
      a3 = a0 + AW'(3);
   end

   // Big-endian read assembly with zero or sign extension
   always_comb begin
      b0    = Mem[a0];
      b1    = Mem[a1];
      b2    = Mem[a2];
      b3    = Mem[a3];
      rdata = '0;
      case (size)
         SZ_BYTE: rdata = {{24{is_signed & b0[7]}}, b0};
         SZ_HALF: rdata = {{16{is_signed & b0[7]}}, b0, b1};
         default: rdata = {b0, b1, b2, b3};
      endcase
   end

   // Storage writes, most significant byte at the lowest address. Reset holds
   // the FSM in IDLE, so an aborted store never reaches this point.
   always_ff @(posedge clk) begin
      if (do_access && !rw_q) begin
         case (size)
            SZ_BYTE: Mem[a0] <= wdata_q[7:0];
            SZ_HALF: begin
               Mem[a0] <= wdata_q[15:8];
               Mem[a1] <= wdata_q[7:0];
            end
            default: begin
               Mem[a0] <= wdata_q[31:24];
               Mem[a1] <= wdata_q[23:16];
               Mem[a2] <= wdata_q[15:8];
               Mem[a3] <= wdata_q[7:0];
            end
         endcase
      end
   end

   // Handshake outputs are registered from the state, which is what puts MOC
   // one edge after the access and drops it one cycle after leaving DONE.
   // DMOC fires on the first cycle MOC is seen high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         DataOut <= '0;
         MOC     <= 1'b0;
         DMOC    <= 1'b0;
      end else begin
         if (do_access && rw_q) DataOut <= rdata;
         MOC  <= (state == DONE);
         DMOC <= (state == DONE) && !MOC;
      end
   end

`ifdef BYTE_RAM_ALIGN_ERR_EN
   logic misaligned;
   logic mis_q;

   // Misalignment of the requested (unmasked) address for the latched size
   always_comb begin
      misaligned = ((size == SZ_HALF) && addr_q[0]) ||
                   ((size == SZ_WORD) && (addr_q[1:0] != 2'b00));
   end

   // Captured at the access and exposed alongside MOC until back in IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mis_q     <= 1'b0;
         align_err <= 1'b0;
      end else begin
         if (do_access) mis_q <= misaligned;
         align_err <= (state == DONE) && mis_q;
      end
   end
`else
   // Misaligned requests are masked without any indication
`endif

endmodule

// File: tb/tb_byte_ram_512.sv
// ----------------------------------------------------------------------------
// tb_byte_ram_512
// Self-checking bench for byte_ram_512: directed scenarios plus randomized
// transactions checked against a byte-array reference model.
// ----------------------------------------------------------------------------
module tb_byte_ram_512;

   logic        clk = 1'b0;
   logic        reset;
   logic        RW;
   logic        MOV;
   logic [8:0]  Address;
   logic [31:0] DataIn;
   logic [5:0]  OpC;
   logic [31:0] DataOut;
   logic        MOC;
   logic        DMOC;
`ifdef BYTE_RAM_ALIGN_ERR_EN
   logic        align_err;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0]  model_mem [512];
   logic [31:0] model_dout;

   int   last_lat;
   int   last_pulses;
   logic last_moc_hold;
   logic last_moc_after1;
   logic last_moc_after2;

   byte_ram_512 dut (
      .clk       (clk),
      .reset     (reset),
`ifdef BYTE_RAM_ALIGN_ERR_EN
      .align_err (align_err),
`endif
      .DataOut   (DataOut),
      .MOC       (MOC),
      .DMOC      (DMOC),
      .RW        (RW),
      .MOV       (MOV),
      .Address   (Address),
      .DataIn    (DataIn),
      .OpC       (OpC)
   );

   always #5 clk = ~clk;

   // Reference model: access width from the opcode, base aligned down,
   // bytes taken big-endian modulo 512
   function automatic int op_bytes(input logic [5:0] opc);
      case (opc)
         6'h20, 6'h24, 6'h28: return 1;
         6'h21, 6'h25, 6'h29: return 2;
         default:             return 4;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input int addr, input logic [5:0] opc);
      int n = op_bytes(opc);
      int base = addr - (addr % n);
      logic [31:0] v = 0;
      for (int k = 0; k < n; k++) v = (v << 8) | 32'(model_mem[(base + k) % 512]);
      if ((opc == 6'h20 || opc == 6'h21) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      return v;
   endfunction

   task automatic model_write(input int addr, input logic [31:0] data, input logic [5:0] opc);
      int n = op_bytes(opc);
      int base = addr - (addr % n);
      for (int k = 0; k < n; k++) model_mem[(base + k) % 512] = 8'(data >> (8 * (n - 1 - k)));
   endtask

   // Drives one complete handshake and records latency, DMOC pulse count and
   // MOC levels around the release of MOV; operands are scrambled once the
   // request has been accepted
   task automatic run_op(input logic rw, input logic [8:0] addr, input logic [31:0] data,
                         input logic [5:0] opc, input int hold);
      @(negedge clk);
      RW = rw; Address = addr; DataIn = data; OpC = opc; MOV = 1'b1;
      last_lat = -1; last_pulses = 0;
      last_moc_hold = 1'b0; last_moc_after1 = 1'b0; last_moc_after2 = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (DMOC) last_pulses++;
         if (MOC) begin
            last_lat = i - 1;
            break;
         end
         if (i == 1) begin
            RW = $urandom_range(0, 1); Address = 9'($urandom);
            DataIn = $urandom; OpC = 6'($urandom);
         end
      end
      if (last_lat < 0) begin
         MOV = 1'b0;
         repeat (4) @(negedge clk);
         return;
      end
      repeat (hold) begin
         @(negedge clk);
         if (DMOC) last_pulses++;
      end
      last_moc_hold = MOC;
      MOV = 1'b0;
      @(negedge clk);
      if (DMOC) last_pulses++;
      last_moc_after1 = MOC;
      @(negedge clk);
      if (DMOC) last_pulses++;
      last_moc_after2 = MOC;
      if (rw) model_dout = model_read(int'(addr), opc);
      else model_write(int'(addr), data, opc);
   endtask

   task automatic fill_memory;
      for (int w = 1; w < 128; w++) run_op(1'b0, 9'(4 * w), $urandom, 6'h2B, 0);
      run_op(1'b0, 9'd0, 32'h8C01_0004, 6'h2B, 0);
   endtask

   task automatic test_reset;
      vectors++;
      if (DataOut !== 32'h0 || MOC !== 1'b0 || DMOC !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL poweron_reset: DataOut=%h MOC=%b DMOC=%b, wanted 0/0/0", DataOut, MOC, DMOC);
      end
      run_op(1'b1, 9'd8, 32'h0, 6'h23, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      vectors++;
      if (DataOut !== 32'h0 || MOC !== 1'b0 || DMOC !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: DataOut=%h MOC=%b DMOC=%b, wanted 0/0/0", DataOut, MOC, DMOC);
      end
      model_dout = 32'h0;
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (dut.Mem[k] !== model_mem[k]) begin
            miscompares++;
            $display("[TB] FAIL reset_keeps_mem[%0d]: got %h wanted %h", k, dut.Mem[k], model_mem[k]);
         end
      end
      run_op(1'b1, 9'd0, 32'h0, 6'h00, 0);
      vectors++;
      if (last_lat !== 3 || last_pulses !== 1) begin
         miscompares++;
         $display("[TB] FAIL first_read_timing: latency %0d pulses %0d, wanted 3 and 1", last_lat, last_pulses);
      end
      vectors++;
      if (DataOut !== 32'h8C01_0004) begin
         miscompares++;
         $display("[TB] FAIL first_read_data: got %h wanted 8c010004", DataOut);
      end
   endtask

   task automatic test_store_load;
      run_op(1'b0, 9'd8, 32'hDEAD_BEEF, 6'h2B, 0);
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (dut.Mem[8 + k] !== model_mem[8 + k]) begin
            miscompares++;
            $display("[TB] FAIL sw_bytes[%0d]: got %h wanted %h", 8 + k, dut.Mem[8 + k], model_mem[8 + k]);
         end
      end
      run_op(1'b1, 9'd8, 32'h0, 6'h23, 0);
      vectors++;
      if (DataOut !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("[TB] FAIL lw_data: got %h wanted deadbeef", DataOut);
      end
   endtask

   task automatic test_sign_ext;
      logic [5:0]  opcs [4] = '{6'h20, 6'h24, 6'h21, 6'h25};
      logic [31:0] want [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
      run_op(1'b0, 9'd16, 32'h0000_0080, 6'h28, 0);
      run_op(1'b0, 9'd17, 32'h0000_0001, 6'h28, 0);
      for (int i = 0; i < 4; i++) begin
         run_op(1'b1, 9'd16, 32'h0, opcs[i], 0);
         vectors++;
         if (DataOut !== want[i]) begin
            miscompares++;
            $display("[TB] FAIL load_ext_opc%h: got %h wanted %h", opcs[i], DataOut, want[i]);
         end
      end
   endtask

   task automatic test_partial_stores;
      run_op(1'b0, 9'd5, 32'h1234_5678, 6'h28, 0);
      for (int k = 4; k <= 6; k++) begin
         vectors++;
         if (dut.Mem[k] !== model_mem[k]) begin
            miscompares++;
            $display("[TB] FAIL sb_bytes[%0d]: got %h wanted %h", k, dut.Mem[k], model_mem[k]);
         end
      end
      run_op(1'b0, 9'd3, 32'h1234_5678, 6'h29, 0);
      vectors++;
      if (dut.Mem[2] !== 8'h56 || dut.Mem[3] !== 8'h78) begin
         miscompares++;
         $display("[TB] FAIL sh_masked: got %h%h wanted 5678", dut.Mem[2], dut.Mem[3]);
      end
      vectors++;
      if (dut.Mem[1] !== model_mem[1] || dut.Mem[4] !== model_mem[4]) begin
         miscompares++;
         $display("[TB] FAIL sh_neighbours: got %h,%h wanted %h,%h", dut.Mem[1], dut.Mem[4], model_mem[1], model_mem[4]);
      end
   endtask

   task automatic test_handshake;
      logic [31:0] expected;
      expected = {model_mem[508], model_mem[509], model_mem[510], model_mem[511]};
      run_op(1'b1, 9'd511, 32'h0, 6'h23, 3);
      vectors++;
      if (DataOut !== expected) begin
         miscompares++;
         $display("[TB] FAIL word_511_masked: got %h wanted %h", DataOut, expected);
      end
      vectors++;
      if (last_lat !== 3 || last_pulses !== 1 || last_moc_hold !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL hold_moc: latency %0d pulses %0d moc_hold %b, wanted 3/1/1", last_lat, last_pulses, last_moc_hold);
      end
      vectors++;
      if (last_moc_after1 !== 1'b1 || last_moc_after2 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL moc_release: got %b%b wanted 10", last_moc_after1, last_moc_after2);
      end
   endtask

   task automatic test_mov_drop_busy;
      int lat = -1;
      @(negedge clk);
      RW = 1'b1; Address = 9'd100; DataIn = 32'h0; OpC = 6'h23; MOV = 1'b1;
      @(negedge clk);
      MOV = 1'b0;
      for (int i = 2; i <= 12; i++) begin
         @(negedge clk);
         if (MOC) begin
            lat = i - 1;
            break;
         end
      end
      model_dout = model_read(100, 6'h23);
      vectors++;
      if (lat !== 3) begin
         miscompares++;
         $display("[TB] FAIL mov_drop_latency: got %0d wanted 3", lat);
      end
      @(negedge clk);
      vectors++;
      if (MOC !== 1'b0 || DataOut !== model_dout) begin
         miscompares++;
         $display("[TB] FAIL mov_drop_complete: MOC=%b DataOut=%h, wanted 0 and %h", MOC, DataOut, model_dout);
      end
   endtask

   task automatic test_reset_busy;
      @(negedge clk);
      RW = 1'b0; Address = 9'd40; OpC = 6'h2B; MOV = 1'b1;
      DataIn = ~{model_mem[40], model_mem[41], model_mem[42], model_mem[43]};
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      vectors++;
      if (MOC !== 1'b0 || DMOC !== 1'b0 || DataOut !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_in_busy: MOC=%b DMOC=%b DataOut=%h, wanted 0/0/0", MOC, DMOC, DataOut);
      end
      model_dout = 32'h0;
      MOV = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int k = 40; k < 44; k++) begin
         vectors++;
         if (dut.Mem[k] !== model_mem[k]) begin
            miscompares++;
            $display("[TB] FAIL aborted_sw[%0d]: got %h wanted %h", k, dut.Mem[k], model_mem[k]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_random;
      logic [5:0] opcs [10] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h0F};
      for (int t = 0; t < 300; t++) begin
         logic [5:0] opc = opcs[$urandom_range(0, 9)];
         logic [8:0] addr = 9'($urandom);
         logic rw;
         int wb;
         if (t % 7 == 0) opc = 6'($urandom);
         rw = (opc == 6'h28 || opc == 6'h29 || opc == 6'h2B) ? 1'b0 :
              (opc inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) ? 1'b1 : 1'($urandom_range(0, 1));
         run_op(rw, addr, $urandom, opc, $urandom_range(0, 2));
         vectors++;
         if (last_lat !== 3 || last_pulses !== 1 || last_moc_after2 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rand%0d_handshake: latency %0d pulses %0d moc_end %b, wanted 3/1/0", t, last_lat, last_pulses, last_moc_after2);
         end
         vectors++;
         if (DataOut !== model_dout) begin
            miscompares++;
            $display("[TB] FAIL rand%0d_dataout opc %h addr %0d: got %h wanted %h", t, opc, addr, DataOut, model_dout);
         end
         wb = int'(addr) & ~3;
         for (int k = 0; k < 4; k++) begin
            vectors++;
            if (dut.Mem[wb + k] !== model_mem[wb + k]) begin
               miscompares++;
               $display("[TB] FAIL rand%0d_mem[%0d]: got %h wanted %h", t, wb + k, dut.Mem[wb + k], model_mem[wb + k]);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b0; RW = 1'b1; MOV = 1'b0;
      Address = '0; DataIn = '0; OpC = '0;
      model_dout = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      fill_memory();
      test_reset();
      test_store_load();
      test_sign_ext();
      test_partial_stores();
      test_handshake();
      test_mov_drop_busy();
      test_reset_busy();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
